// File: rtl/uart_alu_sequencer.sv
// Frames three RX FIFO bytes (A, B, opcode) into registered ALU operands,
// captures the ALU result and pushes it (or an error code) to the TX FIFO.
module uart_alu_sequencer #(
    parameter int unsigned        NB_DATA        = 8,
    parameter int unsigned        NB_OP          = 6,
    parameter int unsigned        NB_TIMEOUT     = 20,
    parameter int unsigned        TIMEOUT_CYCLES = 1000000,
    parameter logic [NB_DATA-1:0] ERR_CODE       = 8'hFF
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_fiforx_EMPTY,
    input  logic [NB_DATA-1:0] i_fiforx_READDATA,
    output logic               o_fiforx_READ,
    input  logic               i_fifotx_FULL,
    output logic               o_fifotx_WRITE,
    output logic [NB_DATA-1:0] o_fifotx_WRITEDATA,
    output logic [NB_DATA-1:0] o_alu_DATAA,
    output logic [NB_DATA-1:0] o_alu_DATAB,
    output logic [NB_OP-1:0]   o_alu_OP,
    input  logic [NB_DATA-1:0] i_alu_RESULT,
    output logic               o_error,
    output logic [7:0]         o_errcount
);

    localparam logic [NB_TIMEOUT-1:0] TMO_LAST = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

    localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'h20);
    localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'h22);
    localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'h24);
    localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'h25);
    localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'h26);
    localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'h27);
    localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'h03);
    localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'h02);

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        SEND    = 3'd4
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [NB_TIMEOUT-1:0] tmo_count;
    logic                  tmo_hit;
    logic                  in_wait_bop;
    logic                  op_valid;
    logic                  rx_read;
    logic                  tx_write;
    logic                  error_pulse;

    assign tmo_hit     = (tmo_count == TMO_LAST);
    assign in_wait_bop = (state == WAIT_B) || (state == WAIT_OP);

    always_comb begin : op_decode
        op_valid = 1'b0;
        case (o_alu_OP)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOR, OP_SRA, OP_SRL: op_valid = 1'b1;
            default:                        op_valid = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin : state_reg
        if (!i_reset) state <= WAIT_A;
        else          state <= state_next;
    end

    always_comb begin : next_state
        state_next = state;
        case (state)
            WAIT_A:  if (!i_fiforx_EMPTY) state_next = WAIT_B;
            WAIT_B: begin
                if (!i_fiforx_EMPTY) state_next = WAIT_OP;
                else if (tmo_hit)    state_next = WAIT_A;
            end
            WAIT_OP: begin
                if (!i_fiforx_EMPTY) state_next = EXEC;
                else if (tmo_hit)    state_next = WAIT_A;
            end
            EXEC:    state_next = SEND;
            SEND:    if (!i_fifotx_FULL) state_next = WAIT_A;
            default: state_next = WAIT_A;
        endcase
    end

    // Strobes are same-cycle handshakes with the FIFOs; reset masks them.
    always_comb begin : outputs
        rx_read     = 1'b0;
        tx_write    = 1'b0;
        error_pulse = 1'b0;
        if (i_reset) begin
            case (state)
                WAIT_A: rx_read = !i_fiforx_EMPTY;
                WAIT_B, WAIT_OP: begin
                    rx_read     = !i_fiforx_EMPTY;
                    error_pulse = i_fiforx_EMPTY && tmo_hit;
                end
                EXEC:    error_pulse = !op_valid;
                SEND:    tx_write    = !i_fifotx_FULL;
                default: ;
            endcase
        end
    end

    assign o_fiforx_READ  = rx_read;
    assign o_fifotx_WRITE = tx_write;
    assign o_error        = error_pulse;

    // Inter-byte timeout: runs only while waiting for B or the opcode.
    always_ff @(posedge i_clk or negedge i_reset) begin : timeout_cnt
        if (!i_reset) begin
            tmo_count <= '0;
        end else if (rx_read || !in_wait_bop || tmo_hit) begin
            tmo_count <= '0;
        end else begin
            tmo_count <= tmo_count + NB_TIMEOUT'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin : datapath
        if (!i_reset) begin
            o_alu_DATAA        <= '0;
            o_alu_DATAB        <= '0;
            o_alu_OP           <= '0;
            o_fifotx_WRITEDATA <= '0;
            o_errcount         <= '0;
        end else begin
            if (rx_read && (state == WAIT_A))  o_alu_DATAA <= i_fiforx_READDATA;
            if (rx_read && (state == WAIT_B))  o_alu_DATAB <= i_fiforx_READDATA;
            if (rx_read && (state == WAIT_OP)) o_alu_OP    <= i_fiforx_READDATA[NB_OP-1:0];
            if (state == EXEC) begin
                o_fifotx_WRITEDATA <= op_valid ? i_alu_RESULT : ERR_CODE;
            end
            if (error_pulse && (o_errcount != 8'hFF)) begin
                o_errcount <= o_errcount + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Directed bench for uart_alu_sequencer: RX FIFO queue model, behavioural ALU,
// and a scoreboard of expected TX bytes checked as the DUT writes them.
module tb_uart_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_empty;
    logic [7:0] rx_data;
    logic       rx_read;
    logic       tx_full;
    logic       tx_write;
    logic [7:0] tx_data;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [5:0] alu_op;
    logic [7:0] alu_result;
    logic       error;
    logic [7:0] errcount;

    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_pops = 0;
    int n_writes = 0;
    int n_err_pulses = 0;
    int last_pop_cycle = 0;
    int last_wr_cycle = 0;

    uart_alu_sequencer #(
        .NB_DATA(8), .NB_OP(6), .NB_TIMEOUT(20), .TIMEOUT_CYCLES(16), .ERR_CODE(8'hFF)
    ) dut (
        .i_clk(clk),
        .i_reset(rst_n),
        .i_fiforx_EMPTY(rx_empty),
        .i_fiforx_READDATA(rx_data),
        .o_fiforx_READ(rx_read),
        .i_fifotx_FULL(tx_full),
        .o_fifotx_WRITE(tx_write),
        .o_fifotx_WRITEDATA(tx_data),
        .o_alu_DATAA(alu_a),
        .o_alu_DATAB(alu_b),
        .o_alu_OP(alu_op),
        .i_alu_RESULT(alu_result),
        .o_error(error),
        .o_errcount(errcount)
    );

    always #5 clk = ~clk;

    // Behavioural ALU; unknown opcodes give 0x5A so a missing error substitution shows up.
    function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [5:0] op);
        case (op)
            6'h20:   return 8'(a + b);
            6'h22:   return 8'(a - b);
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            6'h03:   return 8'($signed(a) >>> b[2:0]);
            6'h02:   return a >> b[2:0];
            default: return 8'h5A;
        endcase
    endfunction

    function automatic logic [7:0] exp_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [5:0] op);
        case (op)
            6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02: return alu_fn(a, b, op);
            default: return 8'hFF;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_a, alu_b, alu_op);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic update_rx();
        rx_empty = (rx_q.size() == 0);
        rx_data  = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
    endtask

    task automatic push_byte(input logic [7:0] b);
        rx_q.push_back(b);
        update_rx();
    endtask

    task automatic push_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        push_byte(a);
        push_byte(b);
        push_byte(op);
        exp_q.push_back(exp_fn(a, b, op[5:0]));
    endtask

    // One clock: observe strobes mid-cycle, then apply the FIFO pop after the edge.
    task automatic tick();
        logic       rd;
        logic [7:0] e;
        @(negedge clk);
        rd = rx_read;
        if (rd) begin
            check("pop_when_empty", 32'(rx_empty), 32'd0);
            n_pops++;
            last_pop_cycle = cyc;
        end
        if (error) n_err_pulses++;
        if (tx_write) begin
            n_writes++;
            last_wr_cycle = cyc;
            check("write_while_full", 32'(tx_full), 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_tx_write", 32'(tx_data), 32'h100);
            end else begin
                e = exp_q.pop_front();
                check("tx_data", 32'(tx_data), 32'(e));
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rd && (rx_q.size() != 0)) void'(rx_q.pop_front());
        update_rx();
    endtask

    task automatic wait_pops(input int target, input string tag);
        int guard = 0;
        while ((n_pops < target) && (guard < 200)) begin
            tick();
            guard++;
        end
        if (n_pops < target) check(tag, 32'(n_pops), 32'(target));
    endtask

    task automatic wait_writes(input int target, input int budget, input string tag);
        int guard = 0;
        while ((n_writes < target) && (guard < budget)) begin
            tick();
            guard++;
        end
        if (n_writes < target) check(tag, 32'(n_writes), 32'(target));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, observed hang, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_p;
        int base_w;
        int base_e;
        int k;
        int hit;

        // Reset with a byte waiting: nothing may be popped, everything reads zero.
        rst_n   = 1'b0;
        tx_full = 1'b0;
        push_byte(8'hAA);
        tick();
        tick();
        check("rst_read",     32'(rx_read),  32'd0);
        check("rst_write",    32'(tx_write), 32'd0);
        check("rst_error",    32'(error),    32'd0);
        check("rst_dataa",    32'(alu_a),    32'd0);
        check("rst_datab",    32'(alu_b),    32'd0);
        check("rst_op",       32'(alu_op),   32'd0);
        check("rst_wdata",    32'(tx_data),  32'd0);
        check("rst_errcount", 32'(errcount), 32'd0);
        check("rst_no_pop",   32'(n_pops),   32'd0);
        rx_q.delete();
        update_rx();
        rst_n = 1'b1;
        tick();

        // ADD frame and two-cycle pop-to-write latency.
        base_p = n_pops;
        base_w = n_writes;
        push_frame(8'h05, 8'h03, 8'h20);
        wait_pops(base_p + 3, "add_pops_timeout");
        wait_writes(base_w + 1, 20, "add_write_timeout");
        check("add_latency", 32'(last_wr_cycle - last_pop_cycle), 32'd2);
        check("add_dataa", 32'(alu_a),  32'h05);
        check("add_datab", 32'(alu_b),  32'h03);
        check("add_op",    32'(alu_op), 32'h20);
        repeat (3) tick();
        check("add_one_write", 32'(n_writes), 32'(base_w + 1));
        check("add_errcount",  32'(errcount), 32'd0);

        // TX FIFO full for ten SEND cycles, then released.
        tx_full = 1'b1;
        base_p  = n_pops;
        base_w  = n_writes;
        push_frame(8'h05, 8'h03, 8'h20);
        wait_pops(base_p + 3, "full_pops_timeout");
        tick();
        repeat (10) tick();
        check("full_no_write", 32'(n_writes), 32'(base_w));
        tx_full = 1'b0;
        tick();
        check("full_release_write", 32'(n_writes), 32'(base_w + 1));
        check("full_write_cycle", 32'(last_wr_cycle), 32'(cyc - 1));

        // Invalid opcode: error code sent, one error pulse.
        base_w = n_writes;
        base_e = n_err_pulses;
        push_frame(8'h10, 8'h20, 8'h3F);
        wait_writes(base_w + 1, 20, "inv_write_timeout");
        repeat (3) tick();
        check("inv_err_pulses", 32'(n_err_pulses - base_e), 32'd1);
        check("inv_errcount",   32'(errcount), 32'd1);

        // Two bytes only: timeout on the 16th empty cycle in WAIT_OP.
        base_p = n_pops;
        base_w = n_writes;
        push_byte(8'h01);
        push_byte(8'h02);
        wait_pops(base_p + 2, "tmo_pops_timeout");
        hit = 0;
        for (k = 1; k <= 40; k++) begin
            base_e = n_err_pulses;
            tick();
            if (n_err_pulses != base_e) begin
                hit = k;
                break;
            end
        end
        check("tmo_cycles",   32'(hit), 32'd16);
        repeat (2) tick();
        check("tmo_errcount", 32'(errcount), 32'd2);
        check("tmo_no_write", 32'(n_writes), 32'(base_w));
        check("tmo_keep_a",   32'(alu_a), 32'h01);
        check("tmo_keep_b",   32'(alu_b), 32'h02);
        push_frame(8'h11, 8'h22, 8'h20);
        wait_writes(base_w + 1, 20, "tmo_next_write_timeout");
        check("tmo_next_a", 32'(alu_a), 32'h11);

        // Reset mid-frame discards the popped operand.
        base_p = n_pops;
        push_byte(8'h09);
        wait_pops(base_p + 1, "rstmid_pop_timeout");
        rst_n = 1'b0;
        tick();
        check("rstmid_dataa",    32'(alu_a),    32'd0);
        check("rstmid_errcount", 32'(errcount), 32'd0);
        rst_n  = 1'b1;
        tick();
        base_w = n_writes;
        push_frame(8'h07, 8'h02, 8'h22);
        wait_writes(base_w + 1, 20, "rstmid_write_timeout");
        check("rstmid_a",  32'(alu_a),  32'h07);
        check("rstmid_b",  32'(alu_b),  32'h02);
        check("rstmid_op", 32'(alu_op), 32'h22);

        // Back-to-back preloaded frames.
        base_w = n_writes;
        push_frame(8'h01, 8'h01, 8'h20);
        push_frame(8'hF0, 8'h0F, 8'h25);
        wait_writes(base_w + 2, 40, "b2b_write_timeout");
        repeat (3) tick();
        check("b2b_writes",   32'(n_writes), 32'(base_w + 2));
        check("b2b_errcount", 32'(errcount), 32'd0);

        // Upper opcode bits are ignored.
        base_w = n_writes;
        push_frame(8'h03, 8'h04, 8'hE0);
        wait_writes(base_w + 1, 20, "upper_write_timeout");
        check("upper_op", 32'(alu_op), 32'h20);

        // 256 invalid frames: error counter saturates at 255.
        base_w = n_writes;
        base_e = n_err_pulses;
        for (int i = 0; i < 256; i++) push_frame(8'(i), 8'h00, 8'h3F);
        wait_writes(base_w + 256, 3000, "sat_write_timeout");
        repeat (3) tick();
        check("sat_pulses",   32'(n_err_pulses - base_e), 32'd256);
        check("sat_errcount", 32'(errcount), 32'd255);
        check("sat_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_alu_sequencer.md
UART_ALU_SEQUENCER -- requirements
Module: uart_alu_sequencer

Interface
REQ-001 Parameter NB_DATA, 8, width of data bytes, operands and result.
REQ-002 Parameter NB_OP, 6, width of the ALU opcode.
REQ-003 Parameter NB_TIMEOUT, 20, width of the inter-byte timeout counter.
REQ-004 Parameter TIMEOUT_CYCLES, 1000000, number of consecutive empty-RX cycles that aborts a partial frame.
REQ-005 Parameter ERR_CODE, 8'hFF, byte transmitted in place of a result for an invalid opcode.
REQ-006 i_clk  in  1  single clock; all state changes on rising edge.
REQ-007 i_reset  in  1  asynchronous, active-low reset.
REQ-008 i_fiforx_EMPTY  in  1  RX FIFO empty flag.
REQ-009 i_fiforx_READDATA  in  NB_DATA  RX FIFO head byte, valid while not empty.
REQ-010 o_fiforx_READ  out  1  one-cycle pop strobe to the RX FIFO.
REQ-011 i_fifotx_FULL  in  1  TX FIFO full flag.
REQ-012 o_fifotx_WRITE  out  1  one-cycle push strobe to the TX FIFO.
REQ-013 o_fifotx_WRITEDATA  out  NB_DATA  byte pushed to the TX FIFO.
REQ-014 o_alu_DATAA / o_alu_DATAB  out  NB_DATA each  registered ALU operands.
REQ-015 o_alu_OP  out  NB_OP  registered ALU opcode.
REQ-016 i_alu_RESULT  in  NB_DATA  combinational ALU result for current operands/opcode.
REQ-017 o_error  out  1  one-cycle pulse on invalid opcode or timeout.
REQ-018 o_errcount  out  8  saturating count of o_error pulses.

Function
REQ-019 Frame = three RX bytes in order: operand A, operand B, opcode (opcode = low NB_OP bits; upper bits ignored).
REQ-020 States: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND; encoded registered FSM.
REQ-021 In each WAIT state, when i_fiforx_EMPTY=0, o_fiforx_READ shall be 1 for exactly that cycle, the head byte captured into the matching register on that edge, and the FSM advances; no state pops more than one byte.
REQ-022 o_fiforx_READ shall be 0 in EXEC and SEND and whenever i_fiforx_EMPTY=1.
REQ-023 Valid opcodes: 6'h20 ADD, 6'h22 SUB, 6'h24 AND, 6'h25 OR, 6'h26 XOR, 6'h27 NOR, 6'h03 SRA, 6'h02 SRL.
REQ-024 EXEC lasts one cycle: result register loads i_alu_RESULT for a valid opcode, ERR_CODE otherwise; invalid opcode pulses o_error in this cycle; FSM -> SEND.
REQ-025 SEND: while i_fifotx_FULL=1 hold with o_fifotx_WRITE=0; first cycle FULL=0 assert o_fifotx_WRITE=1 for one cycle with o_fifotx_WRITEDATA=result, then -> WAIT_A.
REQ-026 Exactly one TX write per completed frame; none for aborted frames.
REQ-027 Timeout counter clears on entry to WAIT_B/WAIT_OP and on every pop; increments each cycle in WAIT_B/WAIT_OP while empty.
REQ-028 Counter reaching TIMEOUT_CYCLES-1 while still empty: discard partial frame, pulse o_error, -> WAIT_A; operand registers retain last values.
REQ-029 o_errcount increments by 1 per o_error pulse and saturates at 255.
REQ-030 Latency from opcode pop to TX write with FULL=0: 2 cycles (EXEC, then write in SEND).
REQ-031 Back-to-back frames: WAIT_A may pop in the cycle after the SEND write; no idle cycles required.

Reset
REQ-032 i_reset=0 shall immediately force state WAIT_A and all outputs, operand/opcode/result registers, timeout counter and o_errcount to 0, regardless of state.
REQ-033 Partial frame at reset is discarded; first byte popped after reset release is operand A.

Verification
REQ-034 RX bytes 0x05,0x03,0x20, ALU model returns 0x08 -> o_alu_DATAA=0x05, DATAB=0x03, OP=0x20; single TX write 0x08 two cycles after third pop.
REQ-035 Same frame with i_fifotx_FULL=1 for 10 cycles from SEND entry -> no write during FULL; one write of 0x08 in first cycle FULL=0.
REQ-036 RX 0x10,0x20,0x3F -> o_error one pulse, TX write 0xFF, o_errcount=1.
REQ-037 TIMEOUT_CYCLES=16, RX 0x01,0x02 only -> after 16 empty cycles in WAIT_OP, o_error pulse, state WAIT_A, no TX write.
REQ-038 Reset asserted after operand A popped, then bytes 0x07,0x02,0x22 -> TX write 0x05 (SUB), no residue from old frame.
REQ-039 Six bytes preloaded (0x01,0x01,0x20, 0xF0,0x0F,0x25) -> two TX writes 0x02 then 0xFF, in order, each exactly once.
